// File: rtl/addac_seq_pkg.sv
// Shared types and vector field layout for the addac self-test sequencer.
// Each vector is packed as {a,b,c,d,e,exp1,exp2}.
package addac_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int VEC_W    = 7;
  localparam int IN_MSB   = 6;
  localparam int IN_LSB   = 2;
  localparam int EXP1_BIT = 1;
  localparam int EXP2_BIT = 0;

endpackage

// File: rtl/addac_seq_vecmem.sv
// Test-vector table: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a loaded table survives a reset.
module addac_seq_vecmem
  import addac_seq_pkg::*;
#(
  parameter int VEC_COUNT = 32,
  parameter int ADDR_W    = $clog2(VEC_COUNT)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [VEC_W-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [VEC_W-1:0]  o_rd_data
);

  logic [VEC_W-1:0] r_mem [VEC_COUNT];

  // Table write port.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/addac_seq.sv
// Self-test sequencer for addac: walks the vector table, drives a..e, samples
// saida1/saida2 after a settle window. Optional ADDAC_SEQ_STOP_ON_ERR_EN ends a run at the first mismatch.
module addac_seq
  import addac_seq_pkg::*;
#(
  parameter int  VEC_COUNT  = 32,
  parameter int  SETTLE_CYC = 1,
  localparam int IDX_W      = $clog2(VEC_COUNT),
  localparam int CNT_W      = $clog2(VEC_COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [VEC_W-1:0] wr_data,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  input  logic             saida1,
  input  logic             saida2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [IDX_W-1:0] vec_idx
);

  localparam int               SCNT_W  = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] ERR_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

  state_t            r_state;
  logic [1:0]        r_exp;
  logic [SCNT_W-1:0] r_settle_cnt;

  logic              w_idle_s;
  logic              w_tbl_wr_en;
  logic [VEC_W-1:0]  w_rd_data;
  logic              w_mismatch;
  logic              w_stop;
  logic [CNT_W-1:0]  w_err_next;

  assign w_idle_s    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_tbl_wr_en = wr_en && w_idle_s;
  assign w_mismatch  = ({saida1, saida2} != r_exp);

  addac_seq_vecmem #(
    .VEC_COUNT (VEC_COUNT),
    .ADDR_W    (IDX_W)
  ) u_vecmem (
    .i_clk     (clk),
    .i_wr_en   (w_tbl_wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (vec_idx),
    .o_rd_data (w_rd_data)
  );

  // Error count after the current CHECK, and whether this CHECK ends the run.
  always_comb begin
    w_err_next = err_count;
    w_stop     = 1'b0;
    if (w_mismatch && (err_count != ERR_MAX)) begin
      w_err_next = err_count + 1'b1;
    end else begin
      w_err_next = err_count;
    end
`ifdef ADDAC_SEQ_STOP_ON_ERR_EN
    w_stop = (vec_idx == LAST_IDX) || w_mismatch;
`else
    w_stop = (vec_idx == LAST_IDX);
`endif
  end

  // Sequencer FSM with registered drive, status and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_exp          <= 2'b00;
      r_settle_cnt   <= '0;
      {a, b, c, d, e} <= 5'b00000;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      vec_idx        <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_count      <= '0;
            first_fail_idx <= '0;
            vec_idx        <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            r_state        <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          {a, b, c, d, e} <= w_rd_data[IN_MSB:IN_LSB];
          r_exp           <= {w_rd_data[EXP1_BIT], w_rd_data[EXP2_BIT]};
          r_settle_cnt    <= SCNT_W'(SETTLE_CYC);
          r_state         <= (SETTLE_CYC > 0) ? ST_SETTLE : ST_CHECK;
        end
        ST_SETTLE: begin
          r_settle_cnt <= r_settle_cnt - 1'b1;
          if (r_settle_cnt <= SCNT_W'(1)) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_count <= w_err_next;
          if (w_mismatch && (err_count == '0)) begin
            first_fail_idx <= vec_idx;
          end
          if (w_stop) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (w_err_next == '0);
            r_state <= ST_DONE;
          end else begin
            vec_idx <= vec_idx + 1'b1;
            r_state <= ST_APPLY;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addac_seq.sv
// Bench for addac_seq: behavioural addac stand-in, cycle-position model of a run,
// a per-cycle compare process and directed literal checks.
module tb_addac_seq;

  localparam int N   = 32;
  localparam int S   = 1;
  localparam int PER = S + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start0, wr_en, wr_en0;
  logic [4:0] wr_addr;
  logic [6:0] wr_data;

  logic       a, b, c, d, e, saida1, saida2, busy, done, pass;
  logic [5:0] err_count;
  logic [4:0] first_fail_idx, vec_idx;

  logic       a0, b0, c0, d0, e0, saida1_0, saida2_0, busy0, done0, pass0;
  logic [5:0] err_count0;
  logic [4:0] first_fail_idx0, vec_idx0;

  // Behavioural addac: two low bits of the population count of a..e.
  function automatic logic [1:0] addac_f(input logic [4:0] v);
    logic [2:0] s;
    s = 3'(v[4]) + 3'(v[3]) + 3'(v[2]) + 3'(v[1]) + 3'(v[0]);
    return s[1:0];
  endfunction

  assign {saida1, saida2}     = addac_f({a, b, c, d, e});
  assign {saida1_0, saida2_0} = addac_f({a0, b0, c0, d0, e0});

  addac_seq #(.VEC_COUNT(N), .SETTLE_CYC(S)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .a(a), .b(b), .c(c), .d(d), .e(e), .saida1(saida1),
    .saida2(saida2), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .vec_idx(vec_idx)
  );

  addac_seq #(.VEC_COUNT(N), .SETTLE_CYC(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .wr_en(wr_en0), .wr_addr(wr_addr),
    .wr_data(wr_data), .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .saida1(saida1_0),
    .saida2(saida2_0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
    .first_fail_idx(first_fail_idx0), .vec_idx(vec_idx0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] tbl [N];
  logic [6:0] snap [N];
  logic [4:0] prev_drv;
  logic [4:0] cur_drv = 5'd0;
  bit         track = 1'b0;
  bit         rst_seen = 1'b1;
  int         ncyc = 0;
  int         t0 = 0;

  function automatic bit mism(input int j);
    return addac_f(snap[j][6:2]) != snap[j][1:0];
  endfunction

  // Expected outputs t cycles after start was sampled, from run position alone.
  task automatic model_at(input int t, output logic [4:0] drv, output logic bsy,
                          output logic dn, output logic ps, output int nerr,
                          output int ff, output int vidx);
    int run_len, endc, v, ph, lim;
    run_len = N;
`ifdef ADDAC_SEQ_STOP_ON_ERR_EN
    for (int j = 0; j < N; j++) begin
      if (mism(j)) begin
        run_len = j + 1;
        break;
      end
    end
`endif
    endc = run_len * PER;
    v    = (t - 1) / PER;
    ph   = (t - 1) % PER;
    lim  = (t <= endc) ? v : run_len;
    nerr = 0;
    ff   = 0;
    for (int j = 0; j < lim; j++) begin
      if (mism(j)) begin
        if (nerr == 0) ff = j;
        nerr++;
      end
    end
    if (t <= endc) begin
      bsy  = 1'b1; dn = 1'b0; ps = 1'b0; vidx = v;
      if (ph != 0)     drv = snap[v][6:2];
      else if (v == 0) drv = prev_drv;
      else             drv = snap[v-1][6:2];
    end else begin
      bsy  = 1'b0; dn = 1'b1; ps = (nerr == 0); vidx = run_len - 1;
      drv  = snap[run_len-1][6:2];
    end
  endtask

  // Compare process: checks every tracked cycle against the run model.
  always @(negedge clk) begin
    logic [4:0] m_drv;
    logic m_bsy, m_dn, m_ps;
    int m_err, m_ff, m_vidx;
    ncyc++;
    if (track) begin
      model_at(ncyc - t0, m_drv, m_bsy, m_dn, m_ps, m_err, m_ff, m_vidx);
      cur_drv = m_drv;
      chk("m_drive", {a, b, c, d, e}, m_drv);
      chk("m_busy", busy, m_bsy);
      chk("m_done", done, m_dn);
      chk("m_pass", pass, m_ps);
      chk("m_err_count", err_count, m_err);
      chk("m_first_fail", first_fail_idx, m_ff);
      chk("m_vec_idx", vec_idx, m_vidx);
    end
  end

  task automatic wr(input int addr, input logic [6:0] data, input bit both);
    @(negedge clk); #1;
    wr_addr = 5'(addr); wr_data = data; wr_en = 1'b1; wr_en0 = both;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_en0 = 1'b0;
    tbl[addr] = data;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    start = 1'b1;
    prev_drv = rst_seen ? 5'd0 : cur_drv;
    rst_seen = 1'b0;
    for (int i = 0; i < N; i++) snap[i] = tbl[i];
    t0 = ncyc;
    track = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Advance to cycle n of the current run (bounded).
  task automatic wait_t(input int n);
    int guard;
    guard = 0;
    while ((ncyc - t0) < n && guard < 300) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 300) chk("wait_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [4:0] vin;
    int k;
    reset = 1'b1; start = 1'b0; start0 = 1'b0; wr_en = 1'b0; wr_en0 = 1'b0;
    wr_addr = 5'd0; wr_data = 7'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_drive", {a, b, c, d, e}, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err", err_count, 6'd0);
    chk("rst_ff", first_fail_idx, 5'd0);
    chk("rst_vidx", vec_idx, 5'd0);
    reset = 1'b0;

    for (int i = 0; i < N; i++) begin
      vin = 5'((i * 7 + 3) % 32);
      wr(i, {vin, addac_f(vin)}, 1'b1);
    end

    // 1: clean run
    pulse_start();
    wait_t(1);  chk("t1_busy_c1", busy, 1'b1);
    wait_t(96); chk("t1_done_c96", done, 1'b0);
    wait_t(97); chk("t1_done_c97", done, 1'b1);
    chk("t1_pass", pass, 1'b1);
    chk("t1_err", err_count, 6'd0);

    // 5: zero settle instance
    @(negedge clk); #1; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    k = 0;
    while (done0 !== 1'b1 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk("t5_done_cycle", k, 65);
    chk("t5_pass", pass0, 1'b1);
    chk("t5_err", err_count0, 6'd0);
    chk("t5_busy", busy0, 1'b0);
    chk("t5_vidx", vec_idx0, 5'd31);
    chk("t5_ff", first_fail_idx0, 5'd0);

    // 2: two corrupted vectors
    wr(5, tbl[5] ^ 7'h03, 1'b0);
    wr(20, tbl[20] ^ 7'h03, 1'b0);
    pulse_start();
    wait_t(97);
    chk("t2_done", done, 1'b1);
    chk("t2_err", err_count, 6'd2);
    chk("t2_ff", first_fail_idx, 5'd5);
    chk("t2_pass", pass, 1'b0);
    wr(5, tbl[5] ^ 7'h03, 1'b0);
    wr(20, tbl[20] ^ 7'h03, 1'b0);

    // 3: start and write while busy are ignored
    pulse_start();
    wait_t(40);
    start = 1'b1; wr_en = 1'b1; wr_addr = 5'd0; wr_data = tbl[0] ^ 7'h7f;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    wait_t(96); chk("t3_done_c96", done, 1'b0);
    wait_t(97); chk("t3_done_c97", done, 1'b1);
    chk("t3_pass", pass, 1'b1);

    // 4: reset mid-run, then rerun without reload
    pulse_start();
    wait_t(50);
    track = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rst_seen = 1'b1;
    chk("t4_drive", {a, b, c, d, e}, 5'd0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    chk("t4_err", err_count, 6'd0);
    chk("t4_vidx", vec_idx, 5'd0);
    pulse_start();
    wait_t(97);
    chk("t4_pass", pass, 1'b1);

    // 6: single corrupted vector
    wr(3, tbl[3] ^ 7'h01, 1'b0);
    pulse_start();
`ifdef ADDAC_SEQ_STOP_ON_ERR_EN
    wait_t(12); chk("t6_done_c12", done, 1'b0);
    wait_t(13); chk("t6_done_c13", done, 1'b1);
    chk("t6_vidx", vec_idx, 5'd3);
`else
    wait_t(96); chk("t6_done_c96", done, 1'b0);
    wait_t(97); chk("t6_done_c97", done, 1'b1);
    chk("t6_vidx", vec_idx, 5'd31);
`endif
    chk("t6_err", err_count, 6'd1);
    chk("t6_ff", first_fail_idx, 5'd3);
    chk("t6_pass", pass, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    track = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addac_seq.md
Name: addac_seq

Overview:
Hardware self-test sequencer for the combinational addac block. It holds a loadable table of test vectors and drives addac inputs a..e from each vector in turn. After a settle window it samples saida1/saida2 against the expected bits and reports pass/fail, the error count and the first failing index. This is the on-chip counterpart of the vector-table bench flow and sits beside addac in the top level.

Parameters:
VEC_COUNT, 32, number of vectors in the table (>=2)
SETTLE_CYC, 1, idle cycles between driving inputs and sampling outputs (>=0)

Ports:
clk  in  1  single system clock, all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a run when idle or done
wr_en  in  1  vector table write strobe
wr_addr  in  $clog2(VEC_COUNT)  table write index
wr_data  in  7  vector {a,b,c,d,e,exp1,exp2}, MSB = a
a, b, c, d, e  out  1 each  registered drive to addac inputs
saida1, saida2  in  1 each  addac outputs
busy  out  1  high in APPLY/SETTLE/CHECK
done  out  1  high in DONE state
pass  out  1  done && err_count==0
err_count  out  $clog2(VEC_COUNT+1)  mismatches in current/last run
first_fail_idx  out  $clog2(VEC_COUNT)  index of first mismatch, valid when err_count!=0
vec_idx  out  $clog2(VEC_COUNT)  current vector index

Behaviour:
- Reset: state IDLE. a..e, busy, done, pass, err_count, first_fail_idx and vec_idx all 0. Table contents are not reset and are retained.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE: wr_en=1 writes table[wr_addr]<=wr_data. start=1 clears err_count, first_fail_idx, vec_idx and done, then goes to APPLY. If wr_en and start occur in the same cycle, the write lands first and the run sees it.
- Busy states: wr_en and start are ignored.
- APPLY (1 cycle): register {a..e}<=table[vec_idx][6:2] and expected<=table[vec_idx][1:0]. Next state is SETTLE if SETTLE_CYC>0, else CHECK.
- SETTLE: counter loaded with SETTLE_CYC; hold for SETTLE_CYC cycles, then go to CHECK. Inputs stay stable.
- CHECK (1 cycle): compare {saida1,saida2} with expected. On mismatch, err_count++ (saturating); if err_count was 0, first_fail_idx<=vec_idx. If vec_idx==VEC_COUNT-1, go to DONE (vec_idx holds); else vec_idx++ and go to APPLY.
- Per-vector cost is SETTLE_CYC+2 cycles. done rises exactly VEC_COUNT*(SETTLE_CYC+2)+1 cycles after the cycle in which start is sampled (97 at defaults).
- DONE: a..e keep the last vector. done, pass and the counts stay stable until start or reset.
- Reset mid-run: abort to IDLE on the next edge with outputs as above.

Optional Feature:
ADDAC_SEQ_STOP_ON_ERR_EN
- Defined: the first mismatch in CHECK jumps straight to DONE with err_count=1 and vec_idx = failing index.
- Undefined: every run executes all VEC_COUNT vectors.

Decomposition:
- Package addac_seq_pkg: state enum type; VEC_W=7; field constants IN_MSB=6, IN_LSB=2, EXP1_BIT=1, EXP2_BIT=0.
- Sub-module addac_seq_vecmem: VEC_COUNT x VEC_W register file with one synchronous write port and one combinational read port, no reset.
- The FSM, counters and compare logic stay in addac_seq.

Test Plan:
1. Load the 32 correct vectors for addac, pulse start -> busy high from cycle 1, done=1 and pass=1 at cycle 97, err_count=0.
2. Flip the expected bits of vectors 5 and 20, run -> err_count=2, first_fail_idx=5, pass=0 at cycle 97.
3. Pulse start and wr_en to address 0 at cycle 40 of a run -> both ignored, table[0] unchanged, done still at cycle 97.
4. Assert reset at cycle 50 -> next cycle all outputs 0 and state IDLE; a new start with no reload gives pass=1, proving the table was retained.
5. Set SETTLE_CYC=0 with passing vectors -> done at cycle 65.
6. Define ADDAC_SEQ_STOP_ON_ERR_EN and corrupt vector 3 -> done at cycle 13, err_count=1, vec_idx=3, first_fail_idx=3, pass=0.
